// File: rtl/store_align.sv
// Store alignment unit: turns a byte/half/word store at any byte address
// into one or two word-aligned memory beats with per-byte write enables.

// One byte lane of the write beat. For the current beat it works out which
// source byte of the store (if any) lands in this lane.
module store_align_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  off_i,
  input  logic [2:0]  nbytes_i,
  input  logic        beat_i,
  input  logic [31:0] wdata_i,
  output logic        we_o,
  output logic [7:0]  byte_o
);
  localparam logic [1:0] LID = 2'(LANE);

  logic [3:0] pos;
  logic [3:0] src;

  // Global byte position of this lane across the two beats, minus the offset,
  // gives the index of the source byte that belongs here.
  always_comb begin
    pos    = {1'b0, beat_i, LID};
    src    = pos - {2'b00, off_i};
    we_o   = (pos >= {2'b00, off_i}) && (src < {1'b0, nbytes_i});
    byte_o = we_o ? wdata_i[{src[1:0], 3'b000} +: 8] : 8'h00;
  end
endmodule

module store_align #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  output logic        done,
  output logic        err
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        split_q, split_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Store size in bytes; zero marks an unsupported funct3.
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3)
      3'b000:  size_bytes = 3'd1;
      3'b001:  size_bytes = 3'd2;
      3'b010:  size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

  logic [2:0] req_nbytes;
  logic       req_split;
  logic       req_illegal;

  // Request decode: a store spills into the next word when off + size > 4.
  always_comb begin
    req_nbytes  = size_bytes(req_funct3);
    req_split   = ({1'b0, req_addr[1:0]} + req_nbytes) > 3'd4;
    req_illegal = (req_nbytes == 3'd0) || (!SPLIT_EN && req_split);
  end

  // State and captured request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      split_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      split_q  <= split_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next state: capture in IDLE, step through beats on mem_ready, pulse
  // done after the last beat or err after a rejected request.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    split_d  = split_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          split_d  = req_split;
          if (req_illegal) err_d   = 1'b1;
          else             state_d = BEAT0;
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (split_q) begin
            state_d = BEAT1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic                       beat1;
  logic [2:0]                 nbytes_q;
  logic [NUM_LANES-1:0]       lane_we;
  logic [NUM_LANES-1:0][7:0]  lane_byte;

  // Beat select and registered store size feeding the lanes.
  always_comb begin
    beat1    = (state_q == BEAT1);
    nbytes_q = size_bytes(funct3_q);
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    store_align_lane #(.LANE(g)) u_lane (
      .off_i    (addr_q[1:0]),
      .nbytes_i (nbytes_q),
      .beat_i   (beat1),
      .wdata_i  (wdata_q),
      .we_o     (lane_we[g]),
      .byte_o   (lane_byte[g])
    );
  end

  // Memory side: beat fields come from registers only, so they stay stable
  // under backpressure; everything is zeroed when no beat is presented.
  always_comb begin
    mem_valid = (state_q == BEAT0) || (state_q == BEAT1);
    mem_we    = mem_valid ? lane_we   : 4'b0000;
    mem_wdata = mem_valid ? lane_byte : 32'h0;
    mem_addr  = mem_valid ? ({addr_q[31:2], 2'b00} + (beat1 ? 32'd4 : 32'd0)) : 32'h0;
    req_ready = rst_n && (state_q == IDLE);
    done      = done_q;
    err       = err_q;
  end
endmodule

// File: tb/tb_store_align.sv
// Bench for store_align: randomized and directed stores, checked by a
// byte-level reference model through a beat scoreboard.
module tb_store_align;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
    bit          last;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic        done;
  logic        err;

  logic        rv_ns;
  logic        rr_ns;
  logic        mv_ns;
  logic [31:0] ma_ns;
  logic [31:0] md_ns;
  logic [3:0]  mw_ns;
  logic        done_ns;
  logic        err_ns;

  int    n_cmp = 0;
  int    n_bad = 0;
  bit    rand_ready = 0;
  bit    ready_force = 1;
  beat_t beat_q[$];
  bit    outc_q[$];

  store_align #(.SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .done(done), .err(err)
  );

  store_align #(.SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_ns), .req_ready(rr_ns),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .mem_valid(mv_ns), .mem_ready(mem_ready), .mem_addr(ma_ns),
    .mem_wdata(md_ns), .mem_we(mw_ns), .done(done_ns), .err(err_ns)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory backpressure: forced level for directed tests, random otherwise.
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: place each store byte k at global byte off+k of a two-word
  // window; word 1 holds anything past byte 3.
  function automatic void model(input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] f3, input bit split_en,
                                output bit rej, output bit spl,
                                output beat_t b0, output beat_t b1);
    int          n;
    int          off;
    logic [3:0]  we [2];
    logic [31:0] dt [2];
    logic [31:0] base;
    case (f3)
      3'd0:    n = 1;
      3'd1:    n = 2;
      3'd2:    n = 4;
      default: n = 0;
    endcase
    off   = int'(a[1:0]);
    base  = a & 32'hFFFF_FFFC;
    we[0] = '0; we[1] = '0; dt[0] = '0; dt[1] = '0;
    for (int k = 0; k < n; k++) begin
      int g;
      g = off + k;
      we[g / 4][g % 4]          = 1'b1;
      dt[g / 4][8*(g % 4) +: 8] = wd[8*k +: 8];
    end
    spl = (we[1] != 4'b0000);
    rej = (n == 0) || (spl && !split_en);
    b0  = '{addr: base,         we: we[0], data: dt[0], last: !spl};
    b1  = '{addr: base + 32'd4, we: we[1], data: dt[1], last: 1'b1};
  endfunction

  task automatic raise(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    beat_t b0, b1;
    bit    rej, spl;
    model(a, wd, f3, 1'b1, rej, spl, b0, b1);
    req_addr   = a;
    req_wdata  = wd;
    req_funct3 = f3;
    req_valid  = 1'b1;
    outc_q.push_back(rej);
    if (!rej) begin
      beat_q.push_back(b0);
      if (spl) beat_q.push_back(b1);
    end
  endtask

  task automatic wait_accept(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      cyc++;
      if (cyc > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: got no req_ready within %0d cycles", cyc);
        break;
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    int c;
    @(posedge clk);
    #1;
    raise(a, wd, f3);
    wait_accept(c);
  endtask

  task automatic drain();
    int c = 0;
    while ((beat_q.size() != 0 || outc_q.size() != 0) && c < 500) begin
      @(negedge clk);
      c++;
    end
    if (c >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", beat_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: pops expected beats on each handshake, checks stability under
  // stall, done after a final beat and err after a rejected acceptance.
  initial begin
    bit    stall_prev = 0;
    bit    exp_done = 0;
    bit    exp_err = 0;
    beat_t held, e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 0; exp_done = 0; exp_err = 0;
        continue;
      end
      chk("done", {31'b0, done}, {31'b0, exp_done});
      chk("err", {31'b0, err}, {31'b0, exp_err});
      exp_done = 0;
      exp_err  = 0;
      if (mem_valid) begin
        chk("beat_expected", {31'b0, beat_q.size() != 0}, 32'd1);
        if (stall_prev) begin
          chk("stable_addr", mem_addr, held.addr);
          chk("stable_we", {28'b0, mem_we}, {28'b0, held.we});
          chk("stable_data", mem_wdata, held.data);
        end
        if (mem_ready && beat_q.size() != 0) begin
          e = beat_q.pop_front();
          chk("beat_addr", mem_addr, e.addr);
          chk("beat_we", {28'b0, mem_we}, {28'b0, e.we});
          chk("beat_data", mem_wdata, e.data);
          exp_done = e.last;
        end
        stall_prev = !mem_ready;
        held = '{addr: mem_addr, we: mem_we, data: mem_wdata, last: 1'b0};
      end else begin
        stall_prev = 0;
        chk("idle_we", {28'b0, mem_we}, 32'd0);
        chk("idle_wdata", mem_wdata, 32'd0);
      end
      if (req_valid && req_ready) begin
        if (outc_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_accept: got acceptance expected none");
        end else begin
          exp_err = outc_q.pop_front();
        end
      end
    end
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int    c;
    beat_t b0, b1;
    bit    rej, spl;
    req_valid = 0; rv_ns = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_mem_we", {28'b0, mem_we}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_done_err", {30'b0, done, err}, 32'd0);

    // SB at 0x1003, presented during reset so it is taken on the first cycle.
    ready_force = 1;
    raise(32'h0000_1003, 32'hAABB_CCDD, 3'b000);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    wait_accept(c);
    chk("first_cycle_accept", c, 0);
    drain();

    // Split SW at 0x2002.
    issue(32'h0000_2002, 32'h1122_3344, 3'b010);
    drain();

    // SH at 0x0005 held off by 3 cycles of backpressure.
    @(negedge clk) ready_force = 0;
    issue(32'h0000_0005, 32'h0000_BEEF, 3'b001);
    repeat (3) begin
      @(negedge clk);
      chk("sh_hold_valid", {31'b0, mem_valid}, 32'd1);
    end
    ready_force = 1;
    drain();

    // Illegal funct3.
    issue(32'h0000_0010, 32'h1234_5678, 3'b011);
    drain();

    // Split store into the non-splitting instance.
    model(32'h0000_0001, 32'hCAFE_F00D, 3'b010, 1'b0, rej, spl, b0, b1);
    @(posedge clk);
    #1;
    req_addr = 32'h0000_0001; req_wdata = 32'hCAFE_F00D; req_funct3 = 3'b010; rv_ns = 1;
    @(negedge clk) chk("ns_ready", {31'b0, rr_ns}, 32'd1);
    @(posedge clk);
    #1 rv_ns = 0;
    @(negedge clk);
    chk("ns_err", {31'b0, err_ns}, {31'b0, rej});
    chk("ns_no_beat", {31'b0, mv_ns}, 32'd0);
    chk("ns_no_done", {31'b0, done_ns}, 32'd0);
    @(negedge clk);
    chk("ns_err_pulse", {31'b0, err_ns}, 32'd0);
    chk("ns_no_beat2", {31'b0, mv_ns}, 32'd0);

    // Second beat address wraps past the top of memory.
    issue(32'hFFFF_FFFE, 32'h5566_7788, 3'b010);
    drain();

    // Reset while the second beat of a split store is stalled.
    @(negedge clk) ready_force = 0;
    issue(32'h0000_3001, 32'h99AA_BBCC, 3'b010);
    @(negedge clk) ready_force = 1;
    @(negedge clk) ready_force = 0;
    @(negedge clk);
    chk("rst_test_in_beat1", mem_addr, 32'h0000_3004);
    #1 rst_n = 1'b0;
    #1;
    beat_q.delete();
    chk("midrst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("midrst_mem_we", {28'b0, mem_we}, 32'd0);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_done_err", {30'b0, done, err}, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready_force = 1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_no_beat", {31'b0, mem_valid}, 32'd0);
    repeat (4) @(negedge clk);

    // Random stores with random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      int          r;
      r  = $urandom_range(0, 9);
      f3 = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
      issue(a, $urandom, f3);
      if ($urandom_range(0, 3) == 0) @(posedge clk);
    end
    drain();
    rand_ready = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/store_align.md
STORE_ALIGN -- requirements
Module: store_align

Interface
REQ-001 SHALL have parameter SPLIT_EN, default 1, meaning: 1 = misaligned stores are split into two word writes; 0 = misaligned stores are rejected with err.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1, store request present.
REQ-005 SHALL have port req_ready, output, 1, block can accept a request.
REQ-006 SHALL have port req_addr, input, 32, byte address of the store.
REQ-007 SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-008 SHALL have port req_funct3, input, 3, store size: 000 SB, 001 SH, 010 SW.
REQ-009 SHALL have port mem_valid, output, 1, memory write beat present.
REQ-010 SHALL have port mem_ready, input, 1, memory accepts the beat.
REQ-011 SHALL have port mem_addr, output, 32, word-aligned write address, with bits [1:0] = 00.
REQ-012 SHALL have port mem_wdata, output, 32, lane-positioned write data.
REQ-013 SHALL have port mem_we, output, 4, byte write enables; bit i covers mem_wdata[8i+7:8i].
REQ-014 SHALL have port done, output, 1, one-cycle pulse when a store completes.
REQ-015 SHALL have port err, output, 1, one-cycle pulse when a request is rejected.

Function
REQ-016 SHALL implement states IDLE, BEAT0 and BEAT1; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request when req_valid & req_ready, registering addr, wdata and funct3 on that edge.
REQ-018 SHALL compute off = addr[1:0] and size mask M = 0001 (SB), 0011 (SH) or 1111 (SW), then the 8-bit enable E = M << off.
REQ-019 SHALL compute the 64-bit data D = {32'b0, wdata} << (8*off); bytes outside M are zero before shifting.
REQ-020 SHALL, for BEAT0, drive mem_addr = {addr[31:2], 2'b00}, mem_we = E[3:0] and mem_wdata = D[31:0].
REQ-021 SHALL, for BEAT1, drive mem_addr = {addr[31:2], 2'b00} + 4 (wrapping modulo 2^32), mem_we = E[7:4] and mem_wdata = D[63:32].
REQ-022 SHALL treat a request as split iff E[7:4] != 0; this covers SH at off 3 and SW at off 1, 2 or 3.
REQ-023 SHALL, on acceptance of a legal request, go IDLE->BEAT0, so mem_valid is first high the cycle after acceptance.
REQ-024 SHALL, in BEAT0 with mem_ready = 1, go to BEAT1 if split, otherwise go to IDLE.
REQ-025 SHALL, in BEAT1 with mem_ready = 1, go to IDLE.
REQ-026 SHALL hold mem_valid = 1 in BEAT0/BEAT1 and 0 in IDLE; mem_addr, mem_wdata and mem_we SHALL stay stable while mem_valid & !mem_ready.
REQ-027 SHALL drive mem_we = 0000 and mem_wdata = 0 whenever mem_valid = 0.
REQ-028 SHALL pulse done for exactly one cycle, in the cycle after the final beat handshake; done coincides with req_ready returning high.
REQ-029 SHALL reject an illegal funct3 (011-111) at acceptance: stay IDLE, pulse err for one cycle the next cycle, no memory beat, no done.
REQ-030 SHALL, when SPLIT_EN = 0, reject a split request exactly as in REQ-029.
REQ-031 SHALL allow minimum occupancy of 1 cycle per beat, so an aligned store with mem_ready held at 1 takes acceptance + 1 cycle.
REQ-032 SHALL ignore req_valid while not in IDLE; the request is not consumed.

Reset
REQ-033 SHALL, on rst_n low and regardless of clk, force state to IDLE and set mem_valid = 0, mem_we = 0000, mem_wdata = 0, mem_addr = 0, done = 0, err = 0; req_ready SHALL be 0 while rst_n = 0.
REQ-034 SHALL abandon any in-flight beat when rst_n is asserted mid-operation; after release, no beat, done or err is produced for the abandoned request.
REQ-035 SHALL accept a request in the first cycle after rst_n is released.

Verification
REQ-036 Bench SHALL check: SB addr 0x1003, wdata 0xAABBCCDD, mem_ready = 1 -> one beat with mem_addr 0x1000, we 1000, wdata 0xDD000000; done the next cycle.
REQ-037 Bench SHALL check: SW addr 0x2002, wdata 0x11223344 -> beat0 at 0x2000, we 1100, wdata 0x33440000; beat1 at 0x2004, we 0011, wdata 0x00001122; single done.
REQ-038 Bench SHALL check: SH addr 0x0005, wdata 0x0000BEEF, mem_ready low for 3 cycles -> mem_valid held with addr 0x0004, we 0110, wdata 0x00BEEF00 stable; done after the handshake.
REQ-039 Bench SHALL check: funct3 = 011, and SW addr 0x0001 with SPLIT_EN = 0 -> err pulse, mem_valid stays 0, no done.
REQ-040 Bench SHALL check: SW addr 0xFFFFFFFE -> beat1 mem_addr wraps to 0x00000000 with we 0011.
REQ-041 Bench SHALL check: rst_n asserted during BEAT1 of a split store -> outputs go to reset values immediately; after release, req_ready = 1 with no stray beat or done.
